// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage
//
// Takes the fetch address from the pc stage and issues one read on the
// instruction bus. It keeps at most one read outstanding. The returned word is
// placed in the if_* output registers for decode. If decode is stalled and its
// slot is still occupied, the word is parked in a one-entry hold buffer.
// An exception flush empties the output slot and the hold buffer. It also
// discards a read that is already in flight.
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   rst           asynchronous, active-low reset
//   pc            fetch address (already muxed with the exception vector)
//   except        exception flush, asserted in the same cycle as the pc stage
//   stall_id      decode cannot accept the if_* entry this cycle
//   fetch_stall   stall to the pc stage; low only when pc is accepted
//   inst_req      instruction bus request
//   inst_addr     instruction bus request address
//   inst_addr_ok  bus accepted the address this cycle
//   inst_data_ok  bus read data valid this cycle
//   inst_rdata    bus read data
//   if_valid      if_pc / if_inst / if_adel valid to decode
//   if_pc         address of the presented instruction
//   if_inst       presented instruction word
//   if_adel       address-error flag of the presented entry
//
// Configuration
//   IF_ADEL_CHECK_EN  when defined, a misaligned pc (pc[1:0] != 0) is not sent
//                     to the bus. Instead it is presented directly to decode as
//                     an address-error entry with if_inst = 0. When undefined,
//                     pc[1:0] is never examined and if_adel is always 0.
// -----------------------------------------------------------------------------

`ifndef W_ADDR
`define W_ADDR 32
`endif

module if_fetch (
   input  logic               clk,
   input  logic               rst,
   input  logic [`W_ADDR-1:0] pc,
   input  logic               except,
   input  logic               stall_id,
   output logic               fetch_stall,
   output logic               inst_req,
   output logic [`W_ADDR-1:0] inst_addr,
   input  logic               inst_addr_ok,
   input  logic               inst_data_ok,
   input  logic [31:0]        inst_rdata,
   output logic               if_valid,
   output logic [`W_ADDR-1:0] if_pc,
   output logic [31:0]        if_inst,
   output logic               if_adel
);

   // IDLE : one cycle after reset, no request
   // ADDR : request on the bus with inst_addr = pc
   // DATA : address accepted, waiting for the read data
   // HOLD : data arrived while decode was stalled, parked in the hold buffer
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      HOLD = 2'd3
   } state_e;

   state_e             state_q,    state_d;
   logic [`W_ADDR-1:0] req_pc_q,   req_pc_d;
   logic               discard_q,  discard_d;
   logic [`W_ADDR-1:0] hold_pc_q,  hold_pc_d;
   logic [31:0]        hold_inst_q, hold_inst_d;
   logic               if_valid_q, if_valid_d;
   logic [`W_ADDR-1:0] if_pc_q,    if_pc_d;
   logic [31:0]        if_inst_q,  if_inst_d;
   logic               if_adel_q,  if_adel_d;

   logic               slot_free;
   logic               pc_misaligned;

   // Output load request and the entry to load, gathered from the FSM.
   logic               load_req;
   logic [`W_ADDR-1:0] load_pc;
   logic [31:0]        load_inst;
   logic               load_adel;

   // Decode can take a new entry at the next edge when it either has nothing
   // now or is consuming what it has.
   assign slot_free = ~if_valid_q | ~stall_id;

`ifdef IF_ADEL_CHECK_EN
   assign pc_misaligned = (state_q == ADDR) && (pc[1:0] != 2'b00);
`else
   assign pc_misaligned = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Bus request and pc-stage handshake (combinational so that reset and
   // inst_addr_ok take effect in the same cycle)
   // ---------------------------------------------------------------------------
   always_comb begin
      inst_req    = 1'b0;
      inst_addr   = pc;
      fetch_stall = 1'b1;
      if (state_q == ADDR) begin
         if (pc_misaligned) begin
            // The error entry goes straight to the output slot, so pc is
            // accepted only when that load can really happen.
            fetch_stall = ~(slot_free & ~except);
         end else begin
            inst_req    = 1'b1;
            fetch_stall = ~inst_addr_ok;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default here first; a path that forgets to
      // assign one would otherwise infer a latch.
      state_d     = state_q;
      req_pc_d    = req_pc_q;
      discard_d   = discard_q;
      hold_pc_d   = hold_pc_q;
      hold_inst_d = hold_inst_q;
      if_pc_d     = if_pc_q;
      if_inst_d   = if_inst_q;
      if_adel_d   = if_adel_q;
      // A presented entry survives only while decode stalls on it.
      if_valid_d  = if_valid_q & stall_id;

      load_req  = 1'b0;
      load_pc   = req_pc_q;
      load_inst = inst_rdata;
      load_adel = 1'b0;

      unique case (state_q)
         IDLE: begin
            state_d = ADDR;
         end

         ADDR: begin
            if (pc_misaligned) begin
               if (slot_free) begin
                  load_req  = 1'b1;
                  load_pc   = pc;
                  load_inst = 32'h0;
                  load_adel = 1'b1;
               end
            end else if (inst_addr_ok) begin
               // An accept during except is the handler fetch, so it is kept.
               req_pc_d  = pc;
               discard_d = 1'b0;
               state_d   = DATA;
            end
         end

         DATA: begin
            if (except) begin
               // The read in flight belongs to the flushed stream. If its data
               // arrives in this same cycle, drop it now. Otherwise remember to
               // drop it when it arrives.
               if (inst_data_ok) begin
                  discard_d = 1'b0;
                  state_d   = ADDR;
               end else begin
                  discard_d = 1'b1;
               end
            end else if (inst_data_ok) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = ADDR;
               end else if (slot_free) begin
                  load_req = 1'b1;
                  state_d  = ADDR;
               end else begin
                  hold_pc_d   = req_pc_q;
                  hold_inst_d = inst_rdata;
                  state_d     = HOLD;
               end
            end
         end

         HOLD: begin
            if (except) begin
               state_d = ADDR;
            end else if (!stall_id) begin
               load_req  = 1'b1;
               load_pc   = hold_pc_q;
               load_inst = hold_inst_q;
               state_d   = ADDR;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // except beats every load and every held entry.
      if (load_req && !except) begin
         if_valid_d = 1'b1;
         if_pc_d    = load_pc;
         if_inst_d  = load_inst;
         if_adel_d  = load_adel;
      end
      if (except) begin
         if_valid_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the datapath registers are reset too, so decode and the hold
         // buffer never expose stale words after reset; they are few and cheap.
         state_q     <= IDLE;
         req_pc_q    <= '0;
         discard_q   <= 1'b0;
         hold_pc_q   <= '0;
         hold_inst_q <= '0;
         if_valid_q  <= 1'b0;
         if_pc_q     <= '0;
         if_inst_q   <= '0;
         if_adel_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples the
         // values from before the edge, whatever the statement order.
         state_q     <= state_d;
         req_pc_q    <= req_pc_d;
         discard_q   <= discard_d;
         hold_pc_q   <= hold_pc_d;
         hold_inst_q <= hold_inst_d;
         if_valid_q  <= if_valid_d;
         if_pc_q     <= if_pc_d;
         if_inst_q   <= if_inst_d;
         if_adel_q   <= if_adel_d;
      end
   end

   assign if_valid = if_valid_q;
   assign if_pc    = if_pc_q;
   assign if_inst  = if_inst_q;
   assign if_adel  = if_adel_q;

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch
//
// The directed part walks the reset, single fetch, back-to-back, decode-stall,
// flush, reset-abort and misaligned-pc scenarios cycle by cycle.
//
// The random part acts as the pc stage and as a bus slave with random latency.
// Each accepted pc is pushed into an expected-stream queue, and an exception
// flushes the queue. A separate monitor pops the queue whenever decode
// consumes an entry and compares the two.
// -----------------------------------------------------------------------------

`ifndef W_ADDR
`define W_ADDR 32
`endif

module tb_if_fetch;

   localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
   localparam logic [31:0] HANDLER  = 32'hbfc0_0380;
   localparam int          N_RAND   = 3000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [`W_ADDR-1:0] pc = RESET_PC;
   logic               except = 1'b0;
   logic               stall_id = 1'b0;
   logic               fetch_stall;
   logic               inst_req;
   logic [`W_ADDR-1:0] inst_addr;
   logic               inst_addr_ok = 1'b0;
   logic               inst_data_ok = 1'b0;
   logic [31:0]        inst_rdata = 32'h0;
   logic               if_valid;
   logic [`W_ADDR-1:0] if_pc;
   logic [31:0]        if_inst;
   logic               if_adel;

   int     n_vec = 0;
   int     n_bad = 0;
   entry_t exp_q[$];
   bit     sb_on = 1'b0;

   // Random-phase pc-stage and bus-slave state
   logic [31:0] cur_pc;
   bit          pend;
   logic [31:0] pend_addr;
   int          pend_cnt;

   always #5 clk = ~clk;

   if_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .pc           (pc),
      .except       (except),
      .stall_id     (stall_id),
      .fetch_stall  (fetch_stall),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .if_valid     (if_valid),
      .if_pc        (if_pc),
      .if_inst      (if_inst),
      .if_adel      (if_adel)
   );

   // Memory contents as a pure function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge, then return at the
   // falling edge, when the outputs are stable.
   task automatic drive(input logic [31:0] p, input logic aok, input logic dok,
                        input logic [31:0] rd, input logic stl, input logic ex);
      @(posedge clk);
      #1;
      pc           = p;
      inst_addr_ok = aok;
      inst_data_ok = dok;
      inst_rdata   = rd;
      stall_id     = stl;
      except       = ex;
      @(negedge clk);
   endtask

   // One random cycle. It acts as the pc stage plus a bus slave with a random
   // read latency. The expected-stream queue is updated from the handshakes.
   // quiet = no new requests, no exceptions, no decode stall.
   task automatic rand_cycle(input bit quiet);
      entry_t e;
      bit     gave;
      @(posedge clk);
      #1;
      except = !quiet && ($urandom_range(0, 24) == 0);
      if (except) cur_pc = HANDLER;
      pc           = cur_pc;
      stall_id     = !quiet && ($urandom_range(0, 2) == 0);
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
      gave         = 1'b0;
      if (pend) begin
         if (pend_cnt == 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_word(pend_addr);
            gave         = 1'b1;
         end else begin
            pend_cnt--;
         end
      end else if ($urandom_range(0, 7) == 0) begin
         // Stray data_ok with no read outstanding; must be ignored.
         inst_data_ok = 1'b1;
      end
      #1;
      inst_addr_ok = inst_req && !quiet && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (except) exp_q.delete();
      if (!fetch_stall) begin
         e.pc   = pc;
         e.inst = mem_word(pc);
         exp_q.push_back(e);
         cur_pc = pc + 32'd4;
      end
      if (gave) pend = 1'b0;
      if (inst_req && inst_addr_ok) begin
         check("bus_addr", inst_addr, pc);
         pend      = 1'b1;
         pend_addr = inst_addr;
         pend_cnt  = $urandom_range(0, 2);
      end
   endtask

   // Scoreboard monitor: every entry decode consumes must be the next one of
   // the expected stream.
   always begin : monitor
      entry_t e;
      @(negedge clk);
      if (sb_on && rst && if_valid && !stall_id && !except) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_extra: got entry pc %0h, expected none", if_pc);
         end else begin
            e = exp_q.pop_front();
            check("sb_entry", {if_pc, if_inst, if_adel}, {e.pc, e.inst, 1'b0});
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      // ---- reset state ----
      #1 rst = 1'b0;
      #1;
      check("rst_inst_req", inst_req, 1'b0);
      check("rst_fetch_stall", fetch_stall, 1'b1);
      check("rst_if_valid", if_valid, 1'b0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_inst", if_inst, 32'h0);
      check("rst_if_adel", if_adel, 1'b0);

      // ---- single fetch after reset release ----
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("idle_inst_req", inst_req, 1'b0);
      check("idle_fetch_stall", fetch_stall, 1'b1);
      drive(RESET_PC, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check("c1_inst_req", inst_req, 1'b1);
      check("c1_inst_addr", inst_addr, RESET_PC);
      check("c1_fetch_stall", fetch_stall, 1'b0);
      drive(RESET_PC + 4, 1'b0, 1'b1, mem_word(RESET_PC), 1'b0, 1'b0);
      check("c2_if_valid", if_valid, 1'b0);
      check("c2_fetch_stall", fetch_stall, 1'b1);
      check("c2_inst_req", inst_req, 1'b0);

      // ---- back-to-back fetches ----
      drive(RESET_PC + 4, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check("b2b_out0", {if_valid, if_pc, if_inst}, {1'b1, RESET_PC, mem_word(RESET_PC)});
      check("b2b_fs0", fetch_stall, 1'b0);
      drive(RESET_PC + 8, 1'b0, 1'b1, mem_word(RESET_PC + 4), 1'b0, 1'b0);
      check("b2b_fs1", fetch_stall, 1'b1);
      // The +4 entry is presented while decode starts stalling.
      drive(RESET_PC + 8, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      check("b2b_out1", {if_valid, if_pc, if_inst}, {1'b1, RESET_PC + 32'd4, mem_word(RESET_PC + 4)});
      check("b2b_fs2", fetch_stall, 1'b0);

      // ---- decode stall: data arrives into HOLD ----
      drive(RESET_PC + 12, 1'b0, 1'b1, mem_word(RESET_PC + 8), 1'b1, 1'b0);
      check("stl_keep0", {if_valid, if_pc}, {1'b1, RESET_PC + 32'd4});
      drive(RESET_PC + 12, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      check("stl_keep1", {if_valid, if_pc, if_inst}, {1'b1, RESET_PC + 32'd4, mem_word(RESET_PC + 4)});
      check("stl_hold_noreq", {inst_req, fetch_stall}, {1'b0, 1'b1});
      drive(RESET_PC + 12, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("stl_keep2", {if_valid, if_pc}, {1'b1, RESET_PC + 32'd4});
      drive(RESET_PC + 12, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("stl_out2", {if_valid, if_pc, if_inst}, {1'b1, RESET_PC + 32'd8, mem_word(RESET_PC + 8)});
      drive(RESET_PC + 12, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("stl_no_dup", if_valid, 1'b0);

      // ---- except while in DATA ----
      drive(RESET_PC + 12, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      drive(HANDLER, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("exc_fs", fetch_stall, 1'b1);
      drive(HANDLER, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      drive(HANDLER, 1'b0, 1'b1, mem_word(RESET_PC + 12), 1'b0, 1'b0);
      check("exc_no_out0", if_valid, 1'b0);
      drive(HANDLER, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("exc_no_out1", if_valid, 1'b0);
      check("exc_next_req", {inst_req, inst_addr}, {1'b1, HANDLER});

      // ---- reset in DATA, stray data_ok after release ----
      drive(HANDLER, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      inst_addr_ok = 1'b0;
      rst          = 1'b0;
      #1;
      check("rstmid_outs", {inst_req, fetch_stall, if_valid}, {1'b0, 1'b1, 1'b0});
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rstmid_idle", inst_req, 1'b0);
      drive(HANDLER, 1'b0, 1'b1, 32'hdead_beef, 1'b0, 1'b0);
      check("rstmid_addr", {inst_req, if_valid}, {1'b1, 1'b0});
      drive(HANDLER, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("rstmid_ignored", {inst_req, if_valid}, {1'b1, 1'b0});

      // ---- misaligned pc ----
      drive(32'hbfc0_0002, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef IF_ADEL_CHECK_EN
      check("adel_noreq", {inst_req, fetch_stall}, {1'b0, 1'b0});
      drive(32'hbfc0_0004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("adel_out", {if_valid, if_adel, if_inst, if_pc}, {1'b1, 1'b1, 32'h0, 32'hbfc0_0002});
`else
      check("noadel_req", {inst_req, inst_addr}, {1'b1, 32'hbfc0_0002});
      check("noadel_flag", if_adel, 1'b0);
`endif

      // ---- randomized traffic against the expected-stream model ----
      cur_pc = 32'hbfc0_1000;
      pend   = 1'b0;
      exp_q.delete();
      sb_on  = 1'b1;
      for (int i = 0; i < N_RAND; i++) rand_cycle(1'b0);
      for (int i = 0; i < 12; i++) rand_cycle(1'b1);
      check("drain_empty", exp_q.size(), 0);
      check("drain_idle", {if_valid, pend}, {1'b0, 1'b0});
      sb_on = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameters: none; address/data width is `W_ADDR (32 bits) from includes.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 pc  in  `W_ADDR  fetch address from pc stage, already muxed with except_addr.
REQ-005 except  in  1  exception flush, same-cycle as pc stage except.
REQ-006 stall_id  in  1  decode stage cannot accept if_* this cycle.
REQ-007 fetch_stall  out  1  drives pc stage stall; 0 only when current pc is accepted.
REQ-008 inst_req  out  1  instruction bus request.
REQ-009 inst_addr  out  `W_ADDR  request address.
REQ-010 inst_addr_ok  in  1  bus accepted address this cycle.
REQ-011 inst_data_ok  in  1  read data valid this cycle.
REQ-012 inst_rdata  in  32  read data.
REQ-013 if_valid  out  1  if_pc/if_inst/if_adel valid to decode.
REQ-014 if_pc  out  `W_ADDR  address of presented instruction.
REQ-015 if_inst  out  32  presented instruction.
REQ-016 if_adel  out  1  address-error flag for presented entry.

Function
REQ-017 States: IDLE, ADDR, DATA, HOLD; at most one outstanding bus read.
REQ-018 IDLE: entered on reset; unconditional ADDR next cycle; inst_req=0, fetch_stall=1.
REQ-019 ADDR: inst_req=1, inst_addr=pc (combinational); on inst_addr_ok latch req_pc<=pc, go DATA; fetch_stall=~inst_addr_ok.
REQ-020 DATA/HOLD/IDLE: inst_req=0, fetch_stall=1.
REQ-021 Output slot free = ~if_valid | ~stall_id.
REQ-022 DATA on inst_data_ok with slot free: if_valid<=1, if_pc<=req_pc, if_inst<=inst_rdata, if_adel<=0, go ADDR.
REQ-023 DATA on inst_data_ok with slot busy: hold_pc/hold_inst<=req_pc/inst_rdata, go HOLD.
REQ-024 HOLD: when stall_id=0 move hold buffer to output regs (if_valid<=1), go ADDR.
REQ-025 Output consumed when if_valid & ~stall_id and no load same edge: if_valid<=0.
REQ-026 Output regs hold value while if_valid & stall_id.
REQ-027 except (priority over stall_id and all loads): if_valid<=0 next edge.
REQ-028 except in ADDR: state stays ADDR; an inst_addr_ok in same cycle is a valid fetch of pc (handler address).
REQ-029 except in DATA: set discard flag; matching inst_data_ok dropped (no output load), discard cleared, go ADDR; data_ok in the except cycle itself is also dropped.
REQ-030 except in HOLD: buffer dropped, go ADDR.
REQ-031 inst_data_ok outside DATA ignored.

Reset
REQ-032 On rst=0: state=IDLE, if_valid=0, if_pc=0, if_inst=0, if_adel=0, discard=0, req_pc=0, hold regs=0; inst_req=0, fetch_stall=1 immediately.
REQ-033 Reset mid-transaction abandons the outstanding read; first data_ok after reset release arrives only in DATA, otherwise ignored.

Configuration
REQ-034 Macro IF_ADEL_CHECK_EN defined: in ADDR with pc[1:0]!=0, inst_req=0; if slot free, load if_valid=1, if_pc=pc, if_inst=0, if_adel=1, fetch_stall=0, stay ADDR; else fetch_stall=1.
REQ-035 IF_ADEL_CHECK_EN undefined: pc[1:0] not examined, inst_addr=pc unmodified, if_adel constant 0.

Verification
REQ-036 Reset release, pc=bfc00000, addr_ok and data_ok each 1 cycle later, stall_id=0 -> inst_req at cycle 1, if_valid=1 if_pc=bfc00000 if_inst=rdata 1 cycle after data_ok.
REQ-037 Back-to-back fetches with addr_ok held 1 -> fetch_stall low once per instruction, if_pc sequence bfc00000, bfc00004, bfc00008.
REQ-038 stall_id=1 for 3 cycles while if_valid, data_ok arrives -> HOLD entered, if_* unchanged, buffered entry presented after stall_id drops, no loss or duplication.
REQ-039 except in DATA with pc=bfc00380, data_ok 2 cycles later -> response dropped, if_valid=0, next inst_addr=bfc00380.
REQ-040 With IF_ADEL_CHECK_EN, pc=bfc00002 -> no inst_req, if_valid=1 if_adel=1 if_inst=0 next cycle; without macro -> inst_req=1 inst_addr=bfc00002.
REQ-041 rst asserted in DATA then released, stray data_ok 1 cycle after release -> ignored, state IDLE then ADDR, if_valid stays 0.
